// File: rtl/ad_wave_pkg.sv
// Shared constants for the ADC capture path: FSM state encodings and trigger edge selects.
package ad_wave_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARM     = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic EDGE_RISE = 1'b0;
  localparam logic EDGE_FALL = 1'b1;

endpackage

// File: rtl/ad_trig_det.sv
// Threshold-crossing detector on decimated samples; remembers the previous strobed sample.
module ad_trig_det
  import ad_wave_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       strobe,
  input  logic [7:0] smp,
  input  logic [7:0] level,
  input  logic       trig_edge,
  input  logic       clear,
  output logic       trig
);

  logic [7:0] prev;
  logic       prev_valid;
  logic       rise_x;
  logic       fall_x;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev       <= 8'd0;
      prev_valid <= 1'b0;
    end else if (clear) begin
      prev_valid <= 1'b0;
    end else if (strobe) begin
      prev       <= smp;
      prev_valid <= 1'b1;
    end
  end

  assign rise_x = (prev <  level) && (smp >= level);
  assign fall_x = (prev >= level) && (smp <  level);
  assign trig   = strobe && prev_valid &&
                  ((trig_edge == EDGE_RISE) ? rise_x : fall_x);

endmodule

// File: rtl/ad_wave_rec.sv
// AD9280-class ADC receiver: arm, wait for a threshold crossing (or timeout), then
// write a fixed-length burst of decimated samples into a capture RAM.
module ad_wave_rec
  import ad_wave_pkg::*;
#(
  parameter logic [7:0]  CLK_DIV      = 8'd0,
  parameter logic [7:0]  TRIG_LEVEL   = 8'd128,
  parameter int          DEPTH_LOG2   = 8,
  parameter logic [15:0] TRIG_TIMEOUT = 16'd65535
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            ad_data,
  input  logic                  ad_otr,
  output logic                  ad_clk,
  input  logic                  start,
  input  logic                  trig_edge,
  output logic                  wr_en,
  output logic [DEPTH_LOG2-1:0] wr_addr,
  output logic [7:0]            wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  trig_auto,
  output logic                  ovr_flag
);

  localparam logic [DEPTH_LOG2-1:0] ADDR_ONE = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2-1:0] ADDR_MAX = '1;

  logic [7:0]            smp;
  logic                  smp_otr;
  logic [7:0]            div_cnt;
  logic                  strobe;
  logic [1:0]            state;
  logic [15:0]           to_cnt;
  logic [15:0]           to_cnt_inc;
  logic                  timeout_hit;
  logic [DEPTH_LOG2-1:0] nxt_addr;
  logic                  fin;
  logic                  trig;
  logic                  arm_clear;

  // The ADC latches on the clk falling edge, so its output is stable at the next rising edge.
  assign ad_clk = ~clk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp     <= 8'd0;
      smp_otr <= 1'b0;
    end else begin
      smp     <= ad_data;
      smp_otr <= ad_otr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 div_cnt <= 8'd0;
    else if (div_cnt == CLK_DIV) div_cnt <= 8'd0;
    else                        div_cnt <= div_cnt + 8'd1;
  end

  assign strobe      = (div_cnt == CLK_DIV);
  assign arm_clear   = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign to_cnt_inc  = (to_cnt == 16'hffff) ? to_cnt : to_cnt + 16'd1;
  assign timeout_hit = (to_cnt_inc >= TRIG_TIMEOUT);
  assign busy        = (state == ST_ARM) || (state == ST_CAPTURE);
  assign done        = (state == ST_DONE);

  ad_trig_det u_trig_det (
    .clk       (clk),
    .rst_n     (rst_n),
    .strobe    (strobe),
    .smp       (smp),
    .level     (TRIG_LEVEL),
    .trig_edge (trig_edge),
    .clear     (arm_clear),
    .trig      (trig)
  );

  // Handshake: start is a one-cycle request honoured only in IDLE/DONE; wr_en is a
  // one-cycle write strobe with wr_addr/wr_data valid in the same cycle, no back-pressure.
  // fin marks that the last address has been issued, so DONE lands one cycle after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      to_cnt    <= 16'd0;
      nxt_addr  <= '0;
      fin       <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= 8'd0;
      trig_auto <= 1'b0;
      ovr_flag  <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state     <= ST_ARM;
            to_cnt    <= 16'd0;
            trig_auto <= 1'b0;
            ovr_flag  <= 1'b0;
          end
        end
        ST_ARM: begin
          if (strobe) begin
            to_cnt <= to_cnt_inc;
            if (trig || timeout_hit) begin
              state     <= ST_CAPTURE;
              trig_auto <= !trig;
              wr_en     <= 1'b1;
              wr_addr   <= '0;
              wr_data   <= smp;
              ovr_flag  <= ovr_flag | smp_otr;
              nxt_addr  <= ADDR_ONE;
              fin       <= 1'b0;
            end
          end
        end
        ST_CAPTURE: begin
          if (fin) begin
            state <= ST_DONE;
            fin   <= 1'b0;
          end else if (strobe) begin
            wr_en    <= 1'b1;
            wr_addr  <= nxt_addr;
            wr_data  <= smp;
            ovr_flag <= ovr_flag | smp_otr;
            nxt_addr <= nxt_addr + ADDR_ONE;
            fin      <= (nxt_addr == ADDR_MAX);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ad_wave_rec.sv
// Bench for ad_wave_rec: three instances (no decimation, CLK_DIV=3, short timeout) share the ADC inputs.
module tb_ad_wave_rec;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ad_data;
  logic       ad_otr = 1'b0;
  logic       trig_edge = 1'b0;
  logic [2:0] start = 3'b000;
  logic [2:0] ad_clk, wr_en, busy, done, trig_auto, ovr_flag;
  logic [7:0] wr_addr [3];
  logic [7:0] wr_data [3];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int mode = 0;
  logic [7:0] const_val = 8'd0;

  logic [7:0] exp_q [$];
  logic [7:0] got_data [$];
  logic [7:0] got_addr [$];
  int         got_cyc [$];

  ad_wave_rec #(.CLK_DIV(8'd0), .TRIG_LEVEL(8'd128), .DEPTH_LOG2(8), .TRIG_TIMEOUT(16'd1000)) u_main (
    .clk(clk), .rst_n(rst_n), .ad_data(ad_data), .ad_otr(ad_otr), .ad_clk(ad_clk[0]),
    .start(start[0]), .trig_edge(trig_edge), .wr_en(wr_en[0]), .wr_addr(wr_addr[0]),
    .wr_data(wr_data[0]), .busy(busy[0]), .done(done[0]), .trig_auto(trig_auto[0]),
    .ovr_flag(ovr_flag[0]));

  ad_wave_rec #(.CLK_DIV(8'd3), .TRIG_LEVEL(8'd128), .DEPTH_LOG2(8), .TRIG_TIMEOUT(16'd1000)) u_div (
    .clk(clk), .rst_n(rst_n), .ad_data(ad_data), .ad_otr(ad_otr), .ad_clk(ad_clk[1]),
    .start(start[1]), .trig_edge(trig_edge), .wr_en(wr_en[1]), .wr_addr(wr_addr[1]),
    .wr_data(wr_data[1]), .busy(busy[1]), .done(done[1]), .trig_auto(trig_auto[1]),
    .ovr_flag(ovr_flag[1]));

  ad_wave_rec #(.CLK_DIV(8'd0), .TRIG_LEVEL(8'd128), .DEPTH_LOG2(8), .TRIG_TIMEOUT(16'd10)) u_to (
    .clk(clk), .rst_n(rst_n), .ad_data(ad_data), .ad_otr(ad_otr), .ad_clk(ad_clk[2]),
    .start(start[2]), .trig_edge(trig_edge), .wr_en(wr_en[2]), .wr_addr(wr_addr[2]),
    .wr_data(wr_data[2]), .busy(busy[2]), .done(done[2]), .trig_auto(trig_auto[2]),
    .ovr_flag(ovr_flag[2]));

  // Clock / cycle counter / ADC stimulus
  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    ad_data = 8'd0;
    forever begin
      @(negedge clk);
      if (mode == 0) ad_data = ad_data + 8'd1;
      else           ad_data = const_val;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic pulse_start(input int k, output int s_cyc);
    @(negedge clk);
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
    s_cyc = cyc;
  endtask

  task automatic collect(input int k, input int budget, output bit saw_done, output int done_cyc);
    got_data.delete();
    got_addr.delete();
    got_cyc.delete();
    saw_done = 1'b0;
    done_cyc = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (wr_en[k]) begin
        got_data.push_back(wr_data[k]);
        got_addr.push_back(wr_addr[k]);
        got_cyc.push_back(cyc);
      end
      if (done[k]) begin
        saw_done = 1'b1;
        done_cyc = cyc;
        break;
      end
    end
  endtask

  // Scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({wr_en[k], busy[k], done[k], trig_auto[k], ovr_flag[k]} !== 5'b0 ||
          wr_addr[k] !== 8'd0 || wr_data[k] !== 8'd0) begin
        failures++;
        $display("FAIL reset_outputs[%0d]: got en/busy/done/auto/ovr=%b addr=%0d data=%0d required all 0",
                 k, {wr_en[k], busy[k], done[k], trig_auto[k], ovr_flag[k]}, wr_addr[k], wr_data[k]);
      end
      checks++;
      if (ad_clk[k] !== 1'b1) begin
        failures++;
        $display("FAIL reset_ad_clk[%0d]: got %b required 1 while clk low", k, ad_clk[k]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_burst(input string name, input int k, input int step, input bit saw_done,
                             input int done_cyc, input bit exp_auto);
    logic [7:0] e;
    int n;
    n = got_data.size();
    checks++;
    if (!saw_done || n != 256) begin
      failures++;
      $display("FAIL %s_count: got %0d writes done_seen=%0b required 256 writes and done", name, n, saw_done);
    end
    for (int i = 0; i < n; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      checks++;
      if (got_data[i] !== e) begin
        failures++;
        $display("FAIL %s_data[%0d]: got %0d required %0d", name, i, got_data[i], e);
      end
      checks++;
      if (got_addr[i] !== 8'(i)) begin
        failures++;
        $display("FAIL %s_addr[%0d]: got %0d required %0d", name, i, got_addr[i], i);
      end
      if (i > 0) begin
        checks++;
        if (got_cyc[i] - got_cyc[i-1] != step) begin
          failures++;
          $display("FAIL %s_spacing[%0d]: got %0d cycles required %0d", name, i, got_cyc[i] - got_cyc[i-1], step);
        end
      end
    end
    exp_q.delete();
    if (n > 0) begin
      checks++;
      if (done_cyc != got_cyc[n-1] + 1) begin
        failures++;
        $display("FAIL %s_done_timing: done at %0d required %0d", name, done_cyc, got_cyc[n-1] + 1);
      end
    end
    checks++;
    if (busy[k] !== 1'b0 || trig_auto[k] !== exp_auto) begin
      failures++;
      $display("FAIL %s_flags: got busy=%b trig_auto=%b required busy=0 trig_auto=%b", name, busy[k], trig_auto[k], exp_auto);
    end
  endtask

  task automatic test_ramp_rise();
    int s; bit sd; int dc;
    mode = 0; trig_edge = 1'b0;
    for (int i = 0; i < 256; i++) exp_q.push_back(8'(128 + i));
    pulse_start(0, s);
    collect(0, 2000, sd, dc);
    check_burst("ramp", 0, 1, sd, dc, 1'b0);
  endtask

  task automatic test_decimate();
    int s; bit sd; int dc;
    mode = 0; trig_edge = 1'b0;
    pulse_start(1, s);
    collect(1, 4000, sd, dc);
    if (got_data.size() > 0) begin
      checks++;
      if (got_data[0] < 8'd128 || got_data[0] > 8'd131) begin
        failures++;
        $display("FAIL decim_first: got %0d required 128..131", got_data[0]);
      end
      for (int i = 0; i < 256; i++) exp_q.push_back(8'(got_data[0] + 8'(4 * i)));
    end
    check_burst("decim", 1, 4, sd, dc, 1'b0);
  endtask

  task automatic test_timeout();
    int s; bit sd; int dc;
    mode = 1; const_val = 8'd50;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 256; i++) exp_q.push_back(8'd50);
    pulse_start(2, s);
    collect(2, 2000, sd, dc);
    checks++;
    if (got_cyc.size() == 0 || got_cyc[0] != s + 10) begin
      failures++;
      $display("FAIL timeout_latency: first write at %0d required %0d", (got_cyc.size() > 0) ? got_cyc[0] : -1, s + 10);
    end
    check_burst("timeout", 2, 1, sd, dc, 1'b1);
  endtask

  task automatic test_falling();
    int s; bit sd; int dc; int n;
    trig_edge = 1'b1; mode = 1; const_val = 8'd200;
    repeat (3) @(negedge clk);
    pulse_start(0, s);
    n = 0;
    repeat (500) begin
      @(negedge clk);
      if (wr_en[0]) n++;
    end
    checks++;
    if (n != 0 || busy[0] !== 1'b1) begin
      failures++;
      $display("FAIL fall_no_trigger: got %0d writes busy=%b required 0 writes busy=1", n, busy[0]);
    end
    const_val = 8'd100;
    for (int i = 0; i < 256; i++) exp_q.push_back(8'd100);
    collect(0, 2000, sd, dc);
    check_burst("fall", 0, 1, sd, dc, 1'b0);
    trig_edge = 1'b0; mode = 0;
  endtask

  task automatic test_overrange();
    int s; bit sd; int dc; bit seen;
    mode = 0;
    pulse_start(0, s);
    seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(negedge clk);
      seen = wr_en[0];
    end
    checks++;
    if (!seen || ovr_flag[0] !== 1'b0) begin
      failures++;
      $display("FAIL ovr_before: write_seen=%b ovr_flag=%b required 1 and 0", seen, ovr_flag[0]);
    end
    repeat (20) @(negedge clk);
    ad_otr = 1'b1;
    @(negedge clk);
    ad_otr = 1'b0;
    collect(0, 600, sd, dc);
    checks++;
    if (!sd || ovr_flag[0] !== 1'b1) begin
      failures++;
      $display("FAIL ovr_sticky: done=%b ovr_flag=%b required 1 and 1", sd, ovr_flag[0]);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (ovr_flag[0] !== 1'b1) begin
      failures++;
      $display("FAIL ovr_hold: got %b required 1", ovr_flag[0]);
    end
    pulse_start(0, s);
    checks++;
    if (ovr_flag[0] !== 1'b0 || done[0] !== 1'b0) begin
      failures++;
      $display("FAIL ovr_clear: got ovr=%b done=%b required 0 and 0", ovr_flag[0], done[0]);
    end
    collect(0, 2000, sd, dc);
    checks++;
    if (!sd || got_data.size() != 256 || ovr_flag[0] !== 1'b0) begin
      failures++;
      $display("FAIL ovr_clean_run: done=%b writes=%0d ovr=%b required 1, 256, 0", sd, got_data.size(), ovr_flag[0]);
    end
  endtask

  task automatic test_reset_mid();
    int s; int n;
    mode = 0;
    pulse_start(0, s);
    n = 0;
    for (int i = 0; i < 1000 && n < 37; i++) begin
      @(negedge clk);
      if (wr_en[0]) n++;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (n != 37 || {wr_en[0], busy[0], done[0], trig_auto[0], ovr_flag[0]} !== 5'b0 ||
        wr_addr[0] !== 8'd0 || wr_data[0] !== 8'd0) begin
      failures++;
      $display("FAIL reset_mid: writes=%0d en/busy/done/auto/ovr=%b addr=%0d data=%0d required 37 writes and all 0",
               n, {wr_en[0], busy[0], done[0], trig_auto[0], ovr_flag[0]}, wr_addr[0], wr_data[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int s; int n; bit sd; int dc; bit injected;
    mode = 0;
    pulse_start(0, s);
    n = 0; sd = 1'b0; injected = 1'b0;
    for (int i = 0; i < 2000 && !sd; i++) begin
      @(negedge clk);
      start[0] = 1'b0;
      if (wr_en[0]) n++;
      if (n == 100 && !injected) begin
        start[0] = 1'b1;
        injected = 1'b1;
      end
      sd = done[0];
    end
    start[0] = 1'b0;
    checks++;
    if (!sd || n != 256) begin
      failures++;
      $display("FAIL restart_ignored: done=%b writes=%0d required 1 and 256", sd, n);
    end
    checks++;
    if (done[0] !== 1'b1) begin
      failures++;
      $display("FAIL done_hold: got %b required 1", done[0]);
    end
    pulse_start(0, s);
    checks++;
    if (done[0] !== 1'b0 || busy[0] !== 1'b1) begin
      failures++;
      $display("FAIL rearm: got done=%b busy=%b required 0 and 1", done[0], busy[0]);
    end
    collect(0, 2000, sd, dc);
    checks++;
    if (!sd || got_data.size() != 256) begin
      failures++;
      $display("FAIL rearm_run: done=%b writes=%0d required 1 and 256", sd, got_data.size());
    end
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_ramp_rise();
    test_decimate();
    test_timeout();
    test_falling();
    test_overrange();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ad_wave_rec.md
Name: ad_wave_rec

Overview:
Receive-side counterpart of the DAC wave sender: drives a parallel 8-bit ADC (AD9280-class) clock and registers its samples.
- After an arm request, waits for a threshold-crossing trigger, or auto-triggers on timeout.
- Then writes a fixed-length burst of decimated samples into a capture RAM through a simple write port.
- Sits between the ADC pins and the capture RAM that the FSK demodulator and display logic read.

Parameters:
CLK_DIV, 8'd0, decimation: one sample strobe every CLK_DIV+1 clk cycles; range 0..255
TRIG_LEVEL, 8'd128, trigger threshold, unsigned offset-binary
DEPTH_LOG2, 8, capture length = 2**DEPTH_LOG2 samples; also the width of wr_addr
TRIG_TIMEOUT, 16'd65535, strobes spent in ARM before auto-trigger

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active-low
ad_data  in  8  ADC parallel output
ad_otr  in  1  ADC out-of-range flag
ad_clk  out  1  ADC sample clock, = ~clk
start  in  1  one-cycle arm pulse
trig_edge  in  1  0 = rising trigger, 1 = falling trigger
wr_en  out  1  RAM write strobe, one cycle per sample
wr_addr  out  DEPTH_LOG2  RAM write address
wr_data  out  8  RAM write data
busy  out  1  high in ARM or CAPTURE
done  out  1  high in DONE until the next accepted start
trig_auto  out  1  capture was started by timeout, not by crossing
ovr_flag  out  1  sticky: ad_otr seen on any written sample

Behaviour:
- Reset values: all outputs 0 except ad_clk (follows ~clk); state IDLE; all counters 0; prev_valid 0.
- ADC data path:
  - ad_clk = ~clk, so the ADC latches on the clk falling edge.
  - ad_data and ad_otr are registered on clk rising edge into smp/smp_otr; the trigger and write logic uses only these registers.
- Decimator:
  - div_cnt counts 0..CLK_DIV and wraps.
  - strobe = (div_cnt == CLK_DIV); with CLK_DIV = 0, strobe is high every cycle.
  - The decimator free-runs in every state and is not reset by start.
- Trigger detection, evaluated on strobe only:
  - prev holds the previous strobed sample; prev_valid sets on the first strobe after entering ARM.
  - Rising trigger: prev_valid && prev < TRIG_LEVEL && smp >= TRIG_LEVEL.
  - Falling trigger: prev_valid && prev >= TRIG_LEVEL && smp < TRIG_LEVEL.
- State machine:
  - IDLE: on start -> ARM; clear ovr_flag, trig_auto, prev_valid and the timeout counter.
  - ARM:
    - Each strobe increments to_cnt.
    - On a trigger strobe -> CAPTURE, and that same sample is written at address 0.
    - If to_cnt reaches TRIG_TIMEOUT on a strobe -> CAPTURE, trig_auto = 1, and that strobe's sample is written at address 0.
    - A real crossing on the same strobe takes priority; trig_auto stays 0.
  - CAPTURE: each strobe writes the next sample. After the write at address 2**DEPTH_LOG2-1 -> DONE.
  - DONE: done = 1. start -> ARM, with the same clears as from IDLE; done drops the cycle after start.
  - start during ARM or CAPTURE is ignored; no restart mid-capture.
- Write port timing:
  - wr_en, wr_addr and wr_data are registered: asserted the cycle after the qualifying strobe.
  - wr_data is the strobed smp value.
  - wr_addr starts at 0 and increments by 1 per write, with no wrap within a capture.
  - Exactly 2**DEPTH_LOG2 wr_en pulses per capture.
  - done rises the cycle after the final wr_en pulse; busy falls in that same cycle.
- ovr_flag: OR of smp_otr over the written samples; sticky until the next accepted start.
- Asynchronous reset mid-capture: immediate return to IDLE with all outputs 0. Partial RAM contents are not cleaned up.
- Widths:
  - All comparisons are unsigned 8-bit.
  - to_cnt is 16 bits and saturates, though it never exceeds TRIG_TIMEOUT.
  - div_cnt is 8 bits.

Decomposition:
- Shared package/include ad_wave_pkg holds:
  - state encodings ST_IDLE, ST_ARM, ST_CAPTURE, ST_DONE (2-bit);
  - the edge-select constants EDGE_RISE = 0 and EDGE_FALL = 1.
- One sub-module, ad_trig_det: owns the prev/prev_valid registers and the crossing comparator. Inputs: strobe, smp, level, edge, clear. Output: trig.

Test Plan:
1. Ramp 0..255 repeating, CLK_DIV = 0, rising edge, TRIG_LEVEL = 128, start pulse -> first wr_en at addr 0 with data 128; 256 consecutive wr_en pulses with data 128..255,0..127; then done = 1, trig_auto = 0.
2. CLK_DIV = 3, same ramp -> wr_en exactly every 4 cycles; data increments by 4 per write; 256 writes total.
3. Constant ad_data = 50, TRIG_TIMEOUT = 10, CLK_DIV = 0 -> capture begins on the 10th strobe in ARM; trig_auto = 1; all 256 writes carry data 50.
4. Falling edge: input 200,200,100,... -> trigger on the 100 sample; addr 0 = 100. A constant 200 without the drop gives no trigger before timeout.
5. ad_otr pulsed high on one written sample -> ovr_flag = 1 after that write and held through done; the next start clears it.
6. Reset asserted at write 37 -> all outputs 0 at once. A second start mid-capture on a separate run is ignored and write count stays 256. start in DONE re-arms and done drops the next cycle.
